// File: rtl/cpu_ocimem_arbiter_pkg.sv
// Shared types and jdo field positions for the OCI RAM arbiter.
// Imported by the arbiter top and its JTAG request register.
package cpu_ocimem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AVM_RD  = 2'd1,
    JTAG_RD = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_kind_t;

  typedef enum logic {
    GNT_JTAG = 1'b0,
    GNT_AVM  = 1'b1
  } grant_t;

  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_HI  = 33;
  localparam int JDO_ADDR_LO  = 26;
  localparam int JDO_WDATA_HI = 34;
  localparam int JDO_WDATA_LO = 3;

endpackage

// File: rtl/cpu_ocimem_jtag_req.sv
// JTAG strobe capture: one-deep request register, overrun flag
// and post-increment of the JTAG word address.
module cpu_ocimem_jtag_req
  import cpu_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              wr_done,
  input  logic              rd_done,
  output logic              jtag_pending,
  output req_kind_t         jtag_kind,
  output logic [ADDR_W-1:0] jtag_addr,
  output logic [DATA_W-1:0] jtag_wdata,
  output logic              jtag_overrun
);

  logic stb_a;
  logic stb_b;
  logic stb_n;
  logic any_stb;
  logic rd_inc;
  logic jdo_unused;

  assign stb_a   = take_action_ocimem_a;
  assign stb_b   = take_action_ocimem_b & ~stb_a;
  assign stb_n   = take_no_action_ocimem_a & ~stb_a
                 & ~take_action_ocimem_b;
  assign any_stb = stb_a | stb_b | stb_n;

  assign jdo_unused = ^{jdo[JDO_W-1:JDO_WDATA_HI+1],
                        jdo[JDO_WDATA_LO-1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_pending <= 1'b0;
      jtag_kind    <= REQ_RD;
      rd_inc       <= 1'b0;
      jtag_addr    <= '0;
      jtag_wdata   <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      if (any_stb && jtag_pending)
        jtag_overrun <= 1'b1;
      if (wr_done || rd_done) begin
        jtag_pending <= 1'b0;
        if (wr_done || rd_inc)
          jtag_addr <= jtag_addr + ADDR_W'(1);
      end else if (any_stb && !jtag_pending) begin
        jtag_pending <= 1'b1;
        unique case (1'b1)
          stb_a: begin
            jtag_kind <= REQ_RD;
            rd_inc    <= 1'b0;
            jtag_addr <= jdo[JDO_ADDR_HI:JDO_ADDR_LO];
          end
          stb_b: begin
            jtag_kind  <= REQ_WR;
            rd_inc     <= 1'b0;
            jtag_wdata <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
          end
          default: begin
            jtag_kind <= REQ_RD;
            rd_inc    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/cpu_ocimem_arbiter.sv
// Round-robin arbiter sharing the OCI debug RAM between the
// JTAG debug slave and the CPU's Avalon debug-memory port.
module cpu_ocimem_arbiter
  import cpu_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteenable,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  arb_state_t        state;
  grant_t            last_grant;
  logic              jtag_pending;
  req_kind_t         jtag_kind;
  logic [ADDR_W-1:0] jtag_addr;
  logic [DATA_W-1:0] jtag_wdata;
  logic              idle;
  logic              avm_req;
  logic              gnt_avm;
  logic              gnt_jtag;
  logic              jtag_wr_done;
  logic              jtag_rd_done;

  cpu_ocimem_jtag_req #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .wr_done                 (jtag_wr_done),
    .rd_done                 (jtag_rd_done),
    .jtag_pending            (jtag_pending),
    .jtag_kind               (jtag_kind),
    .jtag_addr               (jtag_addr),
    .jtag_wdata              (jtag_wdata),
    .jtag_overrun            (jtag_overrun)
  );

  // Grants only exist in IDLE and never while reset is held.
  assign idle     = reset_n & (state == IDLE);
  assign avm_req  = avs_read | avs_write;
  assign gnt_jtag = idle & jtag_pending
                  & (~avm_req | (last_grant == GNT_AVM));
  assign gnt_avm  = idle & avm_req & ~gnt_jtag;

  assign jtag_wr_done = gnt_jtag & (jtag_kind == REQ_WR);
  assign jtag_rd_done = (state == JTAG_RD);
  assign jtag_busy    = jtag_pending;

  assign avs_waitrequest = ~((gnt_avm & avs_write)
                           | (state == AVM_RD));
  assign avs_readdata    = (state == AVM_RD) ? ram_rdata : '0;

  always_comb begin
    ram_addr       = jtag_addr;
    ram_wren       = 1'b0;
    ram_byteenable = 4'hF;
    ram_wdata      = jtag_wdata;
    if (gnt_avm) begin
      ram_addr       = avs_address;
      ram_wren       = avs_write;
      ram_byteenable = avs_byteenable;
      ram_wdata      = avs_writedata;
    end else if (gnt_jtag) begin
      ram_wren = (jtag_kind == REQ_WR);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GNT_JTAG;
      MonDReg    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_avm) begin
            last_grant <= GNT_AVM;
            if (!avs_write)
              state <= AVM_RD;
          end else if (gnt_jtag) begin
            last_grant <= GNT_JTAG;
            if (jtag_kind == REQ_RD)
              state <= JTAG_RD;
          end
        end
        AVM_RD: state <= IDLE;
        JTAG_RD: begin
          MonDReg <= ram_rdata;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
